// File: rtl/pi_event_arbiter.sv
// Event arbiter: latches four single-cycle event pulses, grants them round-robin
// into a timestamped FIFO, and exposes the head entry plus status as an SPI reply word.
module pi_event_arbiter #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned STAMP_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  req,
    input  logic [7:0]  activeopcode,
    input  logic        pulse_load,
    input  logic        flush,
    output logic [23:0] reply,
    output logic [3:0]  grant,
    output logic [3:0]  fifo_count,
    output logic        event_valid,
    output logic        overflow
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned NREQ  = 4;

    typedef struct packed {
        logic [1:0]         src;
        logic [STAMP_W-1:0] stamp;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             head;
    logic [STAMP_W-1:0] stamp_q;
    logic [NREQ-1:0]    pending_q, pending_d;
    logic [NREQ-1:0]    grant_q, win, eff;
    logic [1:0]         rr_q, rr_d, win_idx, idx;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               valid_q;
    logic               op_match, pop, full, can_push, push, drop;

    assign op_match = (activeopcode[7:4] == 4'b0011);
    assign pop      = pulse_load && op_match && (count_q != '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign can_push = !flush && (!full || pop);
    assign eff      = flush ? '0 : (pending_q | req);

    // Round-robin pick starting at rr_q; a fresh req competes in the same cycle it arrives.
    always_comb begin
        win     = '0;
        win_idx = rr_q;
        idx     = '0;
        push    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = rr_q + 2'(k);
            if (!push && can_push && eff[idx]) begin
                win[idx] = 1'b1;
                win_idx  = idx;
                push     = 1'b1;
            end
        end
    end

    // A req on a flag that is granted this cycle re-arms it; on a flag left waiting it is lost.
    always_comb begin
        pending_d  = pending_q;
        overflow_d = overflow_q;
        count_d    = count_q;
        rr_d       = rr_q;
        drop       = 1'b0;
        if (flush) begin
            pending_d  = '0;
            overflow_d = 1'b0;
            count_d    = '0;
        end else begin
            pending_d = (pending_q & ~win) | (req & (pending_q | ~win));
            drop      = |(req & pending_q & ~win);
            if (drop)
                overflow_d = 1'b1;
            else if (pop && (activeopcode == 8'h3F))
                overflow_d = 1'b0;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (push)
                rr_d = win_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stamp_q    <= '0;
            pending_q  <= '0;
            grant_q    <= '0;
            rr_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            stamp_q    <= stamp_q + STAMP_W'(1);
            pending_q  <= pending_d;
            grant_q    <= win;
            rr_q       <= rr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            valid_q    <= (count_d != '0);
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push)
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q] <= '{src: win_idx, stamp: stamp_q};
    end

    assign head = valid_q ? mem[rd_ptr_q] : '0;

    assign reply       = op_match ? {valid_q, overflow_q, count_q[2:0], head.src, 1'b0, head.stamp}
                                  : 24'h0;
    assign grant       = grant_q;
    assign fifo_count  = count_q;
    assign event_valid = valid_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_pi_event_arbiter.sv
// Directed bench for pi_event_arbiter: each task drives one scenario and checks its own results.
module tb_pi_event_arbiter;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req;
    logic [7:0]  activeopcode;
    logic        pulse_load;
    logic        flush;
    logic [23:0] reply;
    logic [3:0]  grant;
    logic [3:0]  fifo_count;
    logic        event_valid;
    logic        overflow;

    int n_cmp;
    int n_bad;
    int cyc;
    int s_pop;

    pi_event_arbiter #(.DEPTH(4), .STAMP_W(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .activeopcode (activeopcode),
        .pulse_load   (pulse_load),
        .flush        (flush),
        .reply        (reply),
        .grant        (grant),
        .fifo_count   (fifo_count),
        .event_valid  (event_valid),
        .overflow     (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        req          = '0;
        activeopcode = 8'h30;
        pulse_load   = 1'b0;
        flush        = 1'b0;
        #2;
        n_cmp++;
        if ({grant, fifo_count, event_valid, overflow} !== 10'b0) begin
            $display("FAIL reset_outputs: got grant=%b count=%0d valid=%b ovf=%b want all 0",
                     grant, fifo_count, event_valid, overflow);
            n_bad++;
        end
        n_cmp++;
        if (reply !== 24'h0) begin
            $display("FAIL reset_reply: got %h want 000000", reply);
            n_bad++;
        end
        tick();
        tick();
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    task automatic test_single();
        repeat (5) tick();
        n_cmp++;
        if (reply !== 24'h0) begin
            $display("FAIL single_empty_reply: got %h want 000000", reply);
            n_bad++;
        end
        req = 4'b0001;
        tick();
        req = '0;
        n_cmp++;
        if (grant !== 4'b0001) begin
            $display("FAIL single_grant: got %b want 0001", grant);
            n_bad++;
        end
        n_cmp++;
        if (reply !== 24'h880005) begin
            $display("FAIL single_reply: got %h want 880005", reply);
            n_bad++;
        end
        tick();
        n_cmp++;
        if (grant !== 4'b0000) begin
            $display("FAIL single_grant_drop: got %b want 0000", grant);
            n_bad++;
        end
        pulse_load = 1'b1;
        tick();
        pulse_load = 1'b0;
        n_cmp++;
        if (fifo_count !== 4'd0 || event_valid !== 1'b0) begin
            $display("FAIL single_pop: got count=%0d valid=%b want 0 0", fifo_count, event_valid);
            n_bad++;
        end
    endtask

    task automatic test_burst();
        logic [3:0] exp_g;
        // Reset mid-stream so the round-robin search restarts at index 0.
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        cyc     = 0;
        req     = 4'b1111;
        tick();
        req = '0;
        for (int k = 0; k < 4; k++) begin
            exp_g = 4'b0001 << k;
            n_cmp++;
            if (grant !== exp_g || fifo_count !== 4'(k + 1)) begin
                $display("FAIL burst_step%0d: got grant=%b count=%0d want grant=%b count=%0d",
                         k, grant, fifo_count, exp_g, k + 1);
                n_bad++;
            end
            tick();
        end
        n_cmp++;
        if (grant !== 4'b0000 || overflow !== 1'b0 || fifo_count !== 4'd4) begin
            $display("FAIL burst_end: got grant=%b ovf=%b count=%0d want 0000 0 4",
                     grant, overflow, fifo_count);
            n_bad++;
        end
    endtask

    task automatic test_full_overflow();
        req = 4'b0010;
        tick();
        req = '0;
        n_cmp++;
        if (grant !== 4'b0000 || overflow !== 1'b0 || fifo_count !== 4'd4) begin
            $display("FAIL full_hold: got grant=%b ovf=%b count=%0d want 0000 0 4",
                     grant, overflow, fifo_count);
            n_bad++;
        end
        tick();
        req = 4'b0010;
        tick();
        req = '0;
        n_cmp++;
        if (grant !== 4'b0000 || overflow !== 1'b1) begin
            $display("FAIL full_drop: got grant=%b ovf=%b want 0000 1", grant, overflow);
            n_bad++;
        end
        n_cmp++;
        if (reply !== 24'hE00000) begin
            $display("FAIL full_reply: got %h want e00000", reply);
            n_bad++;
        end
        activeopcode = 8'h3F;
        pulse_load   = 1'b1;
        s_pop        = cyc;
        tick();
        pulse_load   = 1'b0;
        activeopcode = 8'h30;
        n_cmp++;
        if (grant !== 4'b0010 || fifo_count !== 4'd4 || overflow !== 1'b0) begin
            $display("FAIL full_pop3f: got grant=%b count=%0d ovf=%b want 0010 4 0",
                     grant, fifo_count, overflow);
            n_bad++;
        end
    endtask

    task automatic test_pop_order();
        int          exp_src   [4];
        int          exp_stamp [4];
        logic [23:0] exp_r;
        exp_src   = '{1, 2, 3, 1};
        exp_stamp = '{1, 2, 3, s_pop};
        pulse_load = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_r = {1'b1, 1'b0, 3'(4 - k), 2'(exp_src[k]), 1'b0, 16'(exp_stamp[k])};
            n_cmp++;
            if (reply !== exp_r) begin
                $display("FAIL pop_order%0d: got %h want %h", k, reply, exp_r);
                n_bad++;
            end
            tick();
        end
        n_cmp++;
        if (fifo_count !== 4'd0 || reply !== 24'h0) begin
            $display("FAIL pop_drained: got count=%0d reply=%h want 0 000000", fifo_count, reply);
            n_bad++;
        end
        tick();
        pulse_load = 1'b0;
        n_cmp++;
        if (fifo_count !== 4'd0 || event_valid !== 1'b0 || reply !== 24'h0) begin
            $display("FAIL pop_empty: got count=%0d valid=%b reply=%h want 0 0 000000",
                     fifo_count, event_valid, reply);
            n_bad++;
        end
    endtask

    task automatic test_wrong_opcode();
        req = 4'b0100;
        tick();
        req = '0;
        n_cmp++;
        if (grant !== 4'b0100 || fifo_count !== 4'd1) begin
            $display("FAIL opc_push: got grant=%b count=%0d want 0100 1", grant, fifo_count);
            n_bad++;
        end
        activeopcode = 8'h10;
        pulse_load   = 1'b1;
        #1;
        n_cmp++;
        if (reply !== 24'h0) begin
            $display("FAIL opc_reply: got %h want 000000", reply);
            n_bad++;
        end
        tick();
        pulse_load   = 1'b0;
        activeopcode = 8'h30;
        n_cmp++;
        if (fifo_count !== 4'd1) begin
            $display("FAIL opc_nopop: got count=%0d want 1", fifo_count);
            n_bad++;
        end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        req   = 4'b1000;
        tick();
        flush = 1'b0;
        req   = '0;
        n_cmp++;
        if (fifo_count !== 4'd0 || event_valid !== 1'b0 || grant !== 4'b0000) begin
            $display("FAIL flush_clear: got count=%0d valid=%b grant=%b want 0 0 0000",
                     fifo_count, event_valid, grant);
            n_bad++;
        end
        tick();
        n_cmp++;
        if (grant !== 4'b0000 || fifo_count !== 4'd0) begin
            $display("FAIL flush_discard: got grant=%b count=%0d want 0000 0", grant, fifo_count);
            n_bad++;
        end
        // Last grant before the flush was index 2, so the search must resume at 3.
        req = 4'b1001;
        tick();
        req = '0;
        n_cmp++;
        if (grant !== 4'b1000) begin
            $display("FAIL flush_rr_first: got %b want 1000", grant);
            n_bad++;
        end
        tick();
        n_cmp++;
        if (grant !== 4'b0001 || fifo_count !== 4'd2) begin
            $display("FAIL flush_rr_second: got grant=%b count=%0d want 0001 2", grant, fifo_count);
            n_bad++;
        end
    endtask

    task automatic test_back_to_back();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        req   = 4'b0110;
        tick();
        n_cmp++;
        if (grant !== 4'b0010) begin
            $display("FAIL b2b_first: got %b want 0010", grant);
            n_bad++;
        end
        req = 4'b0100;
        tick();
        req = '0;
        n_cmp++;
        if (grant !== 4'b0100 || overflow !== 1'b0) begin
            $display("FAIL b2b_rearm: got grant=%b ovf=%b want 0100 0", grant, overflow);
            n_bad++;
        end
        tick();
        n_cmp++;
        if (grant !== 4'b0100 || fifo_count !== 4'd3 || overflow !== 1'b0) begin
            $display("FAIL b2b_second: got grant=%b count=%0d ovf=%b want 0100 3 0",
                     grant, fifo_count, overflow);
            n_bad++;
        end
        tick();
        n_cmp++;
        if (grant !== 4'b0000) begin
            $display("FAIL b2b_idle: got %b want 0000", grant);
            n_bad++;
        end
    endtask

    task automatic test_async_reset();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        req   = 4'b0111;
        tick();
        req = 4'b0100;
        tick();
        req = '0;
        n_cmp++;
        if (grant !== 4'b0010 || overflow !== 1'b1) begin
            $display("FAIL contend_drop: got grant=%b ovf=%b want 0010 1", grant, overflow);
            n_bad++;
        end
        tick();
        n_cmp++;
        if (grant !== 4'b0100 || fifo_count !== 4'd3 || overflow !== 1'b1) begin
            $display("FAIL contend_fill: got grant=%b count=%0d ovf=%b want 0100 3 1",
                     grant, fifo_count, overflow);
            n_bad++;
        end
        #1;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({grant, fifo_count, event_valid, overflow} !== 10'b0 || reply !== 24'h0) begin
            $display("FAIL async_reset: got grant=%b count=%0d valid=%b ovf=%b reply=%h want all 0",
                     grant, fifo_count, event_valid, overflow, reply);
            n_bad++;
        end
        reset_n = 1'b1;
        cyc     = 0;
        req     = 4'b0100;
        tick();
        req = '0;
        n_cmp++;
        if (grant !== 4'b0100 || fifo_count !== 4'd1 || reply !== 24'h8C0000) begin
            $display("FAIL post_reset: got grant=%b count=%0d reply=%h want 0100 1 8c0000",
                     grant, fifo_count, reply);
            n_bad++;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        s_pop = 0;
        test_reset();
        test_single();
        test_burst();
        test_full_overflow();
        test_pop_order();
        test_wrong_opcode();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pi_event_arbiter.md
PI_EVENT_ARBITER -- requirements
Module: pi_event_arbiter

Interface
REQ-001 Parameter: DEPTH, default 4; event FIFO depth, power of two, 2..8.
REQ-002 Parameter: STAMP_W, default 16; timestamp width, fixed at 16 for reply packing.
REQ-003 Port: clk  input  1  system clock; all state updates on posedge clk.
REQ-004 Port: reset_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: req  input  4  single-cycle event pulses: [0] correct key, [1] wrong key, [2] life lost, [3] level up.
REQ-006 Port: activeopcode  input  8  current SPI opcode.
REQ-007 Port: pulse_load  input  1  one-cycle SPI transaction-end strobe.
REQ-008 Port: flush  input  1  synchronous clear of pending flags, FIFO and overflow.
REQ-009 Port: reply  output  24  SPI reply word, combinational from head entry and status.
REQ-010 Port: grant  output  4  one-hot, registered; requester accepted into FIFO this cycle.
REQ-011 Port: fifo_count  output  4  number of stored entries, 0..DEPTH.
REQ-012 Port: event_valid  output  1  high when fifo_count != 0.
REQ-013 Port: overflow  output  1  sticky; an event was lost.

Function
REQ-014 Free-running 16-bit stamp counter shall increment every cycle and wrap 16'hFFFF -> 0.
REQ-015 Each requester shall own a pending flag, set on req[i]=1 and cleared on the cycle it is granted.
REQ-016 req[i]=1 while pending[i] is already set and not granted that cycle shall drop the event and set overflow.
REQ-017 req[i]=1 in the same cycle pending[i] is granted shall re-set pending[i]; no drop.
REQ-018 Arbiter shall grant at most one pending requester per cycle, round-robin, starting from the index after the last grant; after reset, search starts at index 0.
REQ-019 No grant shall issue when the FIFO is full and no pop occurs that cycle; pending flags shall hold.
REQ-020 A grant shall write {src[1:0], stamp} into the FIFO tail; stamp is the counter value in the grant cycle.
REQ-021 Latency: req[i] at cycle N with no contention and FIFO not full -> grant[i] high at N+1, entry visible at head (if FIFO was empty) at N+1.
REQ-022 Pop shall occur when pulse_load=1, activeopcode matches 8'b0011zzzz, and fifo_count != 0; pop on empty shall be ignored.
REQ-023 Simultaneous push and pop shall leave fifo_count unchanged; push into full FIFO is permitted only with a same-cycle pop.
REQ-024 For activeopcode 8'b0011zzzz, reply = {event_valid, overflow, fifo_count[2:0], head_src[1:0], 1'b0, head_stamp[15:0]}; head fields 0 when empty.
REQ-025 For all other opcodes, reply shall be 24'h0.
REQ-026 overflow shall clear on a pop with activeopcode 8'h3F; a same-cycle drop shall keep it set.
REQ-027 flush=1 shall clear pending flags, FIFO pointers, fifo_count and overflow at the next edge; req in the flush cycle shall be discarded; round-robin pointer and stamp counter are unaffected.
REQ-028 Read and write pointers shall wrap modulo DEPTH.

Reset
REQ-029 reset_n=0 shall immediately force: pending=0, FIFO empty, fifo_count=0, event_valid=0, overflow=0, grant=0, stamp=0, round-robin pointer=0.
REQ-030 Reset asserted mid-operation shall discard all stored events; the first grant after release follows REQ-021.

Verification
REQ-031 Release reset, pulse req=4'b0001 at stamp 5 -> grant=4'b0001 next cycle; with opcode 8'h30, reply=24'h88_0005 (valid, count 1, src 0, stamp 5).
REQ-032 req=4'b1111 in one cycle, FIFO empty -> grants 0,1,2,3 on four consecutive cycles; fifo_count reaches 4; no overflow.
REQ-033 Fill FIFO (4 entries), pulse req[1] twice without pop -> pending[1] holds, second pulse sets overflow; pop with 8'h3F -> grant[1] same cycle, count stays 4, overflow clears.
REQ-034 Four pops with opcode 8'h30 -> entries returned in grant order; fifth pulse_load -> no change, reply=24'h0 except status fields 0.
REQ-035 Opcode 8'h10 with pulse_load and non-empty FIFO -> no pop, reply=24'h0.
REQ-036 Assert reset_n=0 with 3 entries and overflow=1 -> all outputs 0 without waiting for a clock edge.
